// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the load/store sequencer
//
// Purpose : size encodings, sequencer state enum, data-memory choice codes
//           and the request legality check used at accept time.

package mem_access_pkg;

    // Request size encodings (2'b11 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WR      = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    // Data-memory lane-choice codes; only full-word accesses are issued
    localparam logic [2:0] LC_WORD     = 3'b111;
    localparam logic [2:0] SC_WORD     = 3'b011;
    localparam logic [2:0] CHOICE_NONE = 3'b000;

    // True when the request must be rejected: illegal size or misaligned address
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extraction/extension and store merge
//
// Purpose : combinational lane logic for the load/store sequencer.
// Ports   : word        - full word read from memory
//           off         - byte offset within the word (addr[1:0])
//           size        - SZ_BYTE / SZ_HALF / SZ_WORD
//           ld_unsigned - zero-extend sub-word loads when set
//           wdata       - right-justified store data
//           ld_data     - extended load result
//           st_word     - word with only the addressed lane replaced

module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{off, 3'b000} +: 8];
        half_lane = word[{off[1], 4'b0000} +: 16];
    end

    always_comb begin
        ld_data = word;
        case (size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data = {{16{~ld_unsigned & half_lane[15]}}, half_lane};
            default: ld_data = word;
        endcase
    end

    // Neighbouring bytes come from the sampled read so the full-word write preserves them
    always_comb begin
        st_word = word;
        case (size)
            SZ_BYTE: st_word[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer in front of the data memory
//
// Purpose : accepts one request at a time, checks alignment, issues full-word
//           reads/writes only (sub-word stores as read-modify-write) and
//           returns extended load data with a one-cycle response pulse.
// Ports   : CLK, RST (async, active-low)
//           req_*   - request handshake (req_ready high only in IDLE)
//           resp_*  - completion pulse, load data, error flag
//           mem_*   - data memory word address, write data/enable, choice codes

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    output logic [2:0]        mem_load_choice,
    output logic [2:0]        mem_sw_choice,
    input  logic [31:0]       mem_RD
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [31:0]         ld_data;
    logic [31:0]         st_word;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    err_d   = req_is_bad(req_size, req_addr[1:0]);
                    cnt_d   = '0;
                    if (err_d) begin
                        state_d = ST_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Read is held for MEM_LAT+1 cycles; data is taken on the final edge
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    word_d  = mem_RD;
                    state_d = we_q ? ST_WR : ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_lane_align u_align (
        .word        (word_q),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .ld_unsigned (uns_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    // All outputs decode registered state only, so reset removes them at once
    always_comb begin
        req_ready       = (state_q == ST_IDLE);
        resp_valid      = (state_q == ST_RESP);
        resp_err        = (state_q == ST_RESP) && err_q;
        resp_rdata      = ((state_q == ST_RESP) && !err_q && !we_q) ? ld_data : 32'h0;
        mem_A           = ((state_q == ST_RD_WAIT) || (state_q == ST_WR)) ? addr_q[ADDR_W+1:2] : '0;
        mem_WE          = (state_q == ST_WR);
        mem_WD          = (state_q == ST_WR) ? st_word : 32'h0;
        mem_load_choice = (state_q == ST_RD_WAIT) ? LC_WORD : CHOICE_NONE;
        mem_sw_choice   = (state_q == ST_WR) ? SC_WORD : CHOICE_NONE;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl

module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [2:0]  mem_load_choice;
    logic [2:0]  mem_sw_choice;
    logic [31:0] mem_RD = 32'h0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] wd;
        int          at;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    logic [31:0] mem [0:4095];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Data memory with one-cycle registered read
    always @(posedge CLK) begin
        if (mem_WE) mem[mem_A] <= mem_WD;
        mem_RD <= mem[mem_A];
    end

    mem_access_ctrl #(.ADDR_W(12), .MEM_LAT(1)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_A           (mem_A),
        .mem_WD          (mem_WD),
        .mem_WE          (mem_WE),
        .mem_load_choice (mem_load_choice),
        .mem_sw_choice   (mem_sw_choice),
        .mem_RD          (mem_RD)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response and write monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (RST && resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                check("resp_cycle", cyc, e.at);
            end
        end
        if (RST && mem_WE) begin
            if (wr_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_A", {20'b0, mem_A}, {20'b0, w.a});
                check("mem_WD", mem_WD, w.wd);
                check("mem_sw_choice", {29'b0, mem_sw_choice}, 32'h3);
                check("we_cycle", cyc, w.at);
            end
        end
    end

    // Issue one request; latency counts cycles from accept to the response cycle
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int lat, input logic [31:0] exp_wd);
        int n;
        int acc;
        resp_t r;
        wr_t   w;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge CLK);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.at    = acc + lat - 1;
        resp_q.push_back(r);
        if (we && !exp_err) begin
            w.a  = addr[13:2];
            w.wd = exp_wd;
            w.at = acc + lat - 2;
            wr_q.push_back(w);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("drain", resp_q.size() + wr_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABC;

        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_outputs", {resp_rdata | mem_WD, 20'b0, mem_A} | {31'b0, mem_WE | resp_err},
              32'd0);
        check("rst_choices", {26'b0, mem_load_choice, mem_sw_choice}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Loads from 0x8899AABC at 0x10
        do_req(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFAA, 0, 3, 0);
        do_req(0, 2'b00, 1, 32'h11, 0, 32'h000000AA, 0, 3, 0);
        do_req(0, 2'b01, 0, 32'h12, 0, 32'hFFFF8899, 0, 3, 0);
        do_req(0, 2'b01, 1, 32'h12, 0, 32'h00008899, 0, 3, 0);
        do_req(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF88, 0, 3, 0);
        do_req(0, 2'b00, 1, 32'h10, 0, 32'h000000BC, 0, 3, 0);
        // Sub-word store as read-modify-write, then read back
        do_req(1, 2'b00, 0, 32'h12, 32'hFFFFFF55, 0, 0, 4, 32'h8855AABC);
        do_req(0, 2'b10, 0, 32'h10, 0, 32'h8855AABC, 0, 3, 0);
        do_req(1, 2'b01, 0, 32'h10, 32'hABCD1234, 0, 0, 4, 32'h88551234);
        do_req(0, 2'b01, 0, 32'h10, 0, 32'h00001234, 0, 3, 0);
        // Word store skips the read
        do_req(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 3, 0);
        // Errors: no memory access, response next cycle
        do_req(0, 2'b10, 0, 32'h22, 0, 0, 1, 1, 0);
        do_req(1, 2'b01, 0, 32'h13, 32'h1111, 0, 1, 1, 0);
        do_req(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0);
        do_req(1, 2'b11, 0, 32'h20, 32'h2222, 0, 1, 1, 0);
        drain();

        // Reset during the write cycle of a sub-word store
        do_req(1, 2'b00, 0, 32'h21, 32'h77, 0, 0, 4, 32'hDEAD77EF);
        n = 0;
        while (!mem_WE && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("abort_saw_we", {31'b0, mem_WE}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("abort_we_low", {31'b0, mem_WE}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        resp_q.delete();
        wr_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        do_req(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 3, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer directly upstream of the data memory in the multi-cycle MIPS core. It accepts one memory request at a time from the datapath control FSM and checks alignment. It drives the data memory with full-word reads and writes only: load lane extraction and sign/zero extension happen here, and sub-word stores are done as read-modify-write. This preserves neighbouring bytes, because the memory zero-fills unused lanes on sub-word writes.

Parameters:
ADDR_W, 12, width of the memory word-address port mem_A; mem_A = req_addr[ADDR_W+1:2].
MEM_LAT, 1, memory read latency in clocks (from mem_A driven to mem_RD valid); must be ≥1.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset; asynchronous, active-low.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE; a transfer occurs when req_valid and req_ready are both high.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  1 = zero-extend the load (lbu/lhu); ignored for word loads and stores.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse; cannot be back-pressured.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned or illegal size; valid with resp_valid.
mem_A  out  ADDR_W  word address to the data memory.
mem_WD  out  32  full write word.
mem_WE  out  1  write enable.
mem_load_choice  out  3  111 during reads, else 000.
mem_sw_choice  out  3  011 during writes, else 000.
mem_RD  in  32  memory read data.

Behaviour:
- States: IDLE, RD_WAIT, WR, RESP. Encoding lives in the package.
- Reset (RST low, asynchronous): state = IDLE and all captured registers cleared.
  - Immediately after reset: req_ready = 1 and every other output = 0.
  - mem_WE, mem_load_choice and mem_sw_choice are decoded only from registered state, so an assertion mid-operation drops mem_WE in the same cycle and discards the in-flight request without a response.
- Accept at edge T: capture we, size, unsigned, addr, wdata.
- Error check at accept:
  - size 11 is illegal.
  - half with addr[0] = 1 is misaligned.
  - word with addr[1:0] ≠ 00 is misaligned.
  - Any error goes to RESP with no memory access.
- Transitions:
  - IDLE → RESP on error.
  - IDLE → WR for a word store.
  - IDLE → RD_WAIT for a load or a sub-word store.
  - RD_WAIT lasts MEM_LAT+1 cycles, counted by a counter. mem_RD is sampled at the edge ending its last cycle. Exit to WR for a store, RESP for a load.
  - WR lasts 1 cycle, then RESP.
  - RESP lasts 1 cycle, then IDLE.
- Outputs by state:
  - mem_A is driven from captured addr in RD_WAIT and WR; 0 otherwise.
  - In RD_WAIT: mem_load_choice = 111.
  - In WR: mem_WE = 1, mem_sw_choice = 011, mem_WD = merged word.
  - In RESP: resp_valid = 1.
- Latency with MEM_LAT=1, accept at edge T; resp_valid is high in cycle:
  - error: T+1
  - word store: T+2
  - load: T+3
  - sub-word store: T+4
- Lane rules, little-endian, off = addr[1:0]:
  - Byte load: take word[8*off+7 : 8*off], then sign- or zero-extend.
  - Half load: take word[16*addr[1]+15 : 16*addr[1]], then extend.
  - Word load passes through unchanged.
  - Store merge replaces only the addressed lane with the low bits of wdata; all other bytes keep the sampled read value.
- Throughput: req_ready rises the cycle after RESP, so back-to-back requests are spaced by the request latency + 1.
- req_valid is ignored outside IDLE.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum;
  - memory choice constants LC_WORD = 3'b111, SC_WORD = 3'b011, CHOICE_NONE = 3'b000.
- One combinational sub-module, mem_lane_align. Inputs: word, off, size, unsigned, wdata. Outputs: extended load data and merged store word. It is instantiated once.

Test Plan:
- Memory word 0x8899AABC at byte address 0x10. lb from 0x11 → resp_rdata 0xFFFFFFAA; lbu → 0x000000AA; resp_valid at T+3.
- Same word. lh from 0x12 → 0xFFFF8899; lhu → 0x00008899.
- sb of 0x55 to 0x12 → mem_WE only in T+3, mem_WD 0x8855AABC; a following lw from 0x10 returns 0x8855AABC.
- sw of 0xDEADBEEF to 0x20 → no RD_WAIT; mem_WE only in T+1, mem_A 0x008; resp at T+2 with err 0.
- lw from 0x22, sh to 0x13, and req_size 11 → resp_err 1 at T+1, resp_rdata 0, mem_WE never asserted.
- Drop RST low during the WR cycle of a sub-word store → mem_WE low in the same cycle, no resp_valid, req_ready 1; memory unchanged.
